// File: rtl/serial_lane_pkg.sv
// Shared types and helpers for the serial lane arbiter: state encoding,
// derived-width functions and the frame parity helper.
package serial_lane_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } lane_state_t;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned MAX_WORD = 64;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

  function automatic logic even_parity(input logic [MAX_WORD-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_lane_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]                                  req,
  input  logic [serial_lane_pkg::idx_width(NUM_REQ)-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0]                                  grant,
  output logic [serial_lane_pkg::idx_width(NUM_REQ)-1:0]      grant_idx,
  output logic                                                any_req
);
  import serial_lane_pkg::*;

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  logic found;

  // Scan rr_ptr+1 .. rr_ptr+NUM_REQ so the last winner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    any_req   = |req;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      automatic int unsigned idx = (32'(rr_ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/serial_lane_arbiter.sv
// Round-robin arbiter sharing one serial lane between NUM_REQ word requesters.
// Define SERIAL_LANE_PARITY_EN to append an even-parity bit to every frame.
module serial_lane_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SIZE    = 8,
  parameter int unsigned GAP     = 1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [NUM_REQ-1:0]                                req,
  input  logic [NUM_REQ*SIZE-1:0]                           data,
  output logic [NUM_REQ-1:0]                                ack,
  output logic                                              ser_out,
  output logic                                              ser_valid,
  input  logic                                              ser_ready,
  output logic                                              ser_first,
  output logic [serial_lane_pkg::idx_width(NUM_REQ)-1:0]    grant_id,
  output logic                                              done,
  output logic                                              busy
);
  import serial_lane_pkg::*;

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = count_width(SIZE);
`ifdef SERIAL_LANE_PARITY_EN
  localparam int unsigned FRAME_LEN = SIZE + 1;
`else
  localparam int unsigned FRAME_LEN = SIZE;
`endif
  localparam int unsigned LAST_BIT = FRAME_LEN - 1;
  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  lane_state_t          state, state_nxt;
  logic [SIZE-1:0]      shift_reg, shift_reg_nxt;
  logic [CNT_W-1:0]     bit_count, bit_count_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_nxt;
  logic [NUM_REQ-1:0]   ack_nxt;
  logic                 ser_out_nxt, ser_valid_nxt, ser_first_nxt;
  logic [IDX_W-1:0]     grant_id_nxt;
  logic                 done_nxt, busy_nxt;
`ifdef SERIAL_LANE_PARITY_EN
  logic                 parity_bit, parity_bit_nxt;
`endif

  logic [NUM_REQ-1:0]   win_grant;
  logic [IDX_W-1:0]     win_idx;
  logic                 any_req;
  logic [SIZE-1:0]      win_word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any_req   (any_req)
  );

  // Word of the arbitration winner, selected by the one-hot grant.
  always_comb begin
    win_word = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_grant[i]) win_word = data[i*SIZE +: SIZE];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= serial_lane_pkg::IDLE;
      shift_reg  <= '0;
      bit_count  <= '0;
      rr_ptr     <= IDX_W'(NUM_REQ - 1);
      gap_cnt    <= '0;
      ack        <= '0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      ser_first  <= 1'b0;
      grant_id   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
`ifdef SERIAL_LANE_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_reg_nxt;
      bit_count  <= bit_count_nxt;
      rr_ptr     <= rr_ptr_nxt;
      gap_cnt    <= gap_cnt_nxt;
      ack        <= ack_nxt;
      ser_out    <= ser_out_nxt;
      ser_valid  <= ser_valid_nxt;
      ser_first  <= ser_first_nxt;
      grant_id   <= grant_id_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
`ifdef SERIAL_LANE_PARITY_EN
      parity_bit <= parity_bit_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    shift_reg_nxt  = shift_reg;
    bit_count_nxt  = bit_count;
    rr_ptr_nxt     = rr_ptr;
    gap_cnt_nxt    = gap_cnt;
    ack_nxt        = '0;
    ser_out_nxt    = ser_out;
    ser_valid_nxt  = ser_valid;
    ser_first_nxt  = ser_first;
    grant_id_nxt   = grant_id;
    done_nxt       = 1'b0;
    busy_nxt       = busy;
`ifdef SERIAL_LANE_PARITY_EN
    parity_bit_nxt = parity_bit;
`endif

    case (state)
      serial_lane_pkg::IDLE: begin
        if (any_req) begin
          shift_reg_nxt  = win_word;
          ack_nxt        = win_grant;
          grant_id_nxt   = win_idx;
          rr_ptr_nxt     = win_idx;
          ser_out_nxt    = win_word[SIZE-1];
          ser_valid_nxt  = 1'b1;
          ser_first_nxt  = 1'b1;
          busy_nxt       = 1'b1;
          bit_count_nxt  = '0;
          state_nxt      = serial_lane_pkg::SHIFT;
`ifdef SERIAL_LANE_PARITY_EN
          parity_bit_nxt = even_parity(MAX_WORD'(win_word));
`endif
        end
      end

      // Advance only on an accepted handshake; a stall holds everything.
      serial_lane_pkg::SHIFT: begin
        if (ser_ready) begin
          ser_first_nxt = 1'b0;
          if (bit_count == CNT_W'(LAST_BIT)) begin
            ser_valid_nxt = 1'b0;
            ser_out_nxt   = 1'b0;
            done_nxt      = 1'b1;
            bit_count_nxt = '0;
            if (GAP > 0) begin
              gap_cnt_nxt = '0;
              state_nxt   = serial_lane_pkg::GAP;
            end else begin
              busy_nxt  = 1'b0;
              state_nxt = serial_lane_pkg::IDLE;
            end
          end else begin
            shift_reg_nxt = shift_reg << 1;
            ser_out_nxt   = shift_reg_nxt[SIZE-1];
            bit_count_nxt = bit_count + CNT_W'(1);
`ifdef SERIAL_LANE_PARITY_EN
            if (bit_count == CNT_W'(SIZE - 1)) ser_out_nxt = parity_bit;
`endif
          end
        end
      end

      serial_lane_pkg::GAP: begin
        if (gap_cnt == GAP_W'(GAP_LAST)) begin
          busy_nxt  = 1'b0;
          state_nxt = serial_lane_pkg::IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end

      default: state_nxt = serial_lane_pkg::IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Scoreboard bench for serial_lane_arbiter: grants and serial bits are queued
// as expectations when stimulus is driven and checked as the lane emits them.
module tb_serial_lane_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned SZ = 8;
  localparam int unsigned GP = 1;
`ifdef SERIAL_LANE_PARITY_EN
  localparam int unsigned FRAME_LEN = SZ + 1;
  localparam bit          PAR       = 1'b1;
`else
  localparam int unsigned FRAME_LEN = SZ;
  localparam bit          PAR       = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*SZ-1:0]  data;
  logic [NR-1:0]     ack;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_first;
  logic [1:0]        grant_id;
  logic              done;
  logic              busy;

  serial_lane_arbiter #(
    .NUM_REQ (NR),
    .SIZE    (SZ),
    .GAP     (GP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_first (ser_first),
    .grant_id  (grant_id),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic b;
    logic first;
    logic last;
  } exp_bit_t;

  exp_bit_t exp_bits[$];
  int       exp_grant[$];
  logic     done_due  = 1'b0;
  logic     prev_busy = 1'b0;

  // Scoreboard monitor: pops expected grants and bits as the DUT produces them.
  always @(negedge clk) begin
    if (reset) begin
      done_due  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (done_due || done) begin
        checks++;
        if (done !== done_due) begin
          errors++;
          $display("FAIL done_timing: got %0b expected %0b at cycle %0d", done, done_due, cyc);
        end
      end
      done_due = 1'b0;
      if (ack !== '0) begin
        checks++;
        if (exp_grant.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got ack=%b expected none", ack);
        end else begin
          automatic int id = exp_grant.pop_front();
          if (ack !== NR'(1 << id) || grant_id !== 2'(id) || prev_busy !== 1'b0) begin
            errors++;
            $display("FAIL grant: got ack=%b id=%0d prev_busy=%b expected ack=%b id=%0d prev_busy=0",
                     ack, grant_id, prev_busy, NR'(1 << id), id);
          end
        end
      end
      if (ser_valid && ser_ready) begin
        checks++;
        if (exp_bits.size() == 0) begin
          errors++;
          $display("FAIL stray_bit: got ser_out=%b expected no bit", ser_out);
        end else begin
          automatic exp_bit_t e = exp_bits.pop_front();
          if (ser_out !== e.b || ser_first !== e.first) begin
            errors++;
            $display("FAIL ser_bit: got out=%b first=%b expected out=%b first=%b",
                     ser_out, ser_first, e.b, e.first);
          end
          if (e.last) done_due = 1'b1;
        end
      end
      prev_busy = busy;
    end
  end

  task automatic push_frame(input int id, input logic [SZ-1:0] word);
    exp_bit_t e;
    exp_grant.push_back(id);
    for (int i = SZ - 1; i >= 0; i--) begin
      e.b     = word[i];
      e.first = (i == SZ - 1);
      e.last  = (i == 0) && !PAR;
      exp_bits.push_back(e);
    end
    if (PAR) begin
      e.b     = ^word;
      e.first = 1'b0;
      e.last  = 1'b1;
      exp_bits.push_back(e);
    end
  endtask

  task automatic wait_ack(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (ack !== '0) seen = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && ser_valid === 1'b0) seen = 1'b1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    exp_bits.delete();
    exp_grant.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; data = '0; ser_ready = 1'b0;
    @(negedge clk);
    checks++; if (ack !== '0)         begin errors++; $display("FAIL rst_ack: got %b expected 0", ack); end
    checks++; if (ser_out !== 1'b0)   begin errors++; $display("FAIL rst_ser_out: got %b expected 0", ser_out); end
    checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL rst_ser_valid: got %b expected 0", ser_valid); end
    checks++; if (ser_first !== 1'b0) begin errors++; $display("FAIL rst_ser_first: got %b expected 0", ser_first); end
    checks++; if (grant_id !== 2'd0)  begin errors++; $display("FAIL rst_grant_id: got %0d expected 0", grant_id); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single();
    bit seen;
    push_frame(0, 8'hA5);
    @(posedge clk);
    #1 req = 4'b0001; data[0 +: SZ] = 8'hA5; ser_ready = 1'b1;
    wait_ack(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL single_ack: got no ack expected ack"); end
    @(negedge clk);
    checks++; if (ack !== '0) begin errors++; $display("FAIL single_ack_pulse: got %b expected 0", ack); end
    @(posedge clk);
    #1 req = '0;
    wait_done(30, seen);
    checks++; if (!seen) begin errors++; $display("FAIL single_done: got no done expected done"); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant_id: got %0d expected 0", grant_id); end
    wait_idle(10, seen);
    checks++; if (!seen || exp_bits.size() != 0) begin
      errors++; $display("FAIL single_drain: got idle=%b left=%0d expected idle=1 left=0", seen, exp_bits.size());
    end
  endtask

  task automatic test_round_robin();
    bit seen;
    int last_done;
    logic [SZ-1:0] words [NR] = '{8'h3C, 8'h96, 8'h5A, 8'hC3};
    apply_reset();
    for (int i = 0; i < int'(NR); i++) data[i*SZ +: SZ] = words[i];
    for (int f = 0; f < 5; f++) push_frame(f % NR, words[f % NR]);
    req = 4'b1111; ser_ready = 1'b1;
    last_done = 0;
    for (int f = 0; f < 5; f++) begin
      wait_ack(40, seen);
      checks++; if (!seen) begin errors++; $display("FAIL rr_ack%0d: got no ack expected ack", f); end
      if (f > 0) begin
        checks++;
        if (cyc - last_done != int'(GP) + 1) begin
          errors++; $display("FAIL rr_gap%0d: got %0d expected %0d", f, cyc - last_done, GP + 1);
        end
      end
      if (f == 4) begin
        @(posedge clk);
        #1 req = '0;
      end
      wait_done(40, seen);
      checks++; if (!seen) begin errors++; $display("FAIL rr_done%0d: got no done expected done", f); end
      last_done = cyc;
    end
    wait_idle(10, seen);
    checks++; if (!seen || exp_grant.size() != 0) begin
      errors++; $display("FAIL rr_drain: got idle=%b grants_left=%0d expected 1 0", seen, exp_grant.size());
    end
  endtask

  task automatic test_stall();
    bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit   finished = 1'b0;
    int   accepted = 0;
    logic pv = 1'b0, pr = 1'b0, po = 1'b0, pf = 1'b0;
    push_frame(2, 8'hF0);
    @(posedge clk);
    #1 req = 4'b0100; data[2*SZ +: SZ] = 8'hF0;
    for (int i = 0; i < 100 && !finished; i++) begin
      @(posedge clk);
      #1 ser_ready = pat[i % 4];
      if (i == 2) req = '0;
      @(negedge clk);
      if (pv && !pr) begin
        checks++;
        if (ser_valid !== 1'b1 || ser_out !== po || ser_first !== pf) begin
          errors++; $display("FAIL stall_hold: got v=%b o=%b f=%b expected v=1 o=%b f=%b",
                             ser_valid, ser_out, ser_first, po, pf);
        end
      end
      if (ser_valid && ser_ready) accepted++;
      if (done) finished = 1'b1;
      pv = ser_valid; pr = ser_ready; po = ser_out; pf = ser_first;
    end
    ser_ready = 1'b1;
    checks++; if (!finished) begin errors++; $display("FAIL stall_done: got no done expected done"); end
    checks++; if (accepted != int'(FRAME_LEN)) begin
      errors++; $display("FAIL stall_count: got %0d expected %0d", accepted, FRAME_LEN);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    int accepted = 0;
    int dones = 0;
    push_frame(0, 8'hA5);
    @(posedge clk);
    #1 req = 4'b0001; data[0 +: SZ] = 8'hA5; ser_ready = 1'b1;
    for (int i = 0; i < 40 && accepted < 4; i++) begin
      @(negedge clk);
      if (ser_valid && ser_ready) accepted++;
      if (ack !== '0) req = '0;
    end
    #1 reset = 1'b1; req = '0;
    exp_bits.delete();
    exp_grant.delete();
    @(negedge clk);
    checks++;
    if ({ack, ser_out, ser_valid, ser_first, done, busy, grant_id} !== '0) begin
      errors++; $display("FAIL abort_outputs: got ack=%b o=%b v=%b f=%b d=%b b=%b id=%0d expected all 0",
                         ack, ser_out, ser_valid, ser_first, done, busy, grant_id);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    push_frame(1, 8'h69);
    @(posedge clk);
    #1 req = 4'b0010; data[SZ +: SZ] = 8'h69;
    wait_ack(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL abort_regrant: got no ack expected ack"); end
    @(posedge clk);
    #1 req = '0;
    wait_done(30, seen);
    checks++; if (!seen || grant_id !== 2'd1) begin
      errors++; $display("FAIL abort_grant_id: got done=%b id=%0d expected 1 1", seen, grant_id);
    end
    wait_idle(10, seen);
  endtask

  task automatic test_withdraw();
    bit seen;
    int acks1 = 0;
    push_frame(0, 8'h3C);
    @(posedge clk);
    #1 req = 4'b0001; data[0 +: SZ] = 8'h3C;
    wait_ack(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL withdraw_ack0: got no ack expected ack"); end
    @(posedge clk);
    #1 req = '0;
    @(posedge clk);
    #1 req = 4'b0010;
    @(posedge clk);
    #1 req = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ack[1]) acks1++;
    end
    checks++; if (acks1 != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL withdraw: got acks1=%0d busy=%b expected 0 0", acks1, busy);
    end
  endtask

  task automatic test_parity_word();
    bit seen = 1'b0;
    int accepted = 0;
    push_frame(3, 8'h07);
    @(posedge clk);
    #1 req = 4'b1000; data[3*SZ +: SZ] = 8'h07; ser_ready = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack !== '0) req = '0;
      if (ser_valid && ser_ready) accepted++;
      if (done) seen = 1'b1;
    end
    checks++; if (!seen || accepted != int'(FRAME_LEN)) begin
      errors++; $display("FAIL frame_len: got done=%b bits=%0d expected 1 %0d", seen, accepted, FRAME_LEN);
    end
    wait_idle(10, seen);
    checks++; if (exp_bits.size() != 0 || exp_grant.size() != 0) begin
      errors++; $display("FAIL final_drain: got bits=%0d grants=%0d expected 0 0", exp_bits.size(), exp_grant.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_abort();
    test_withdraw();
    test_parity_word();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
